// File: rtl/uart_host_ctrl.sv
// Host-side master for the UART register port: runs the init writes, then moves
// bytes between a TX stream FIFO, the UART data register and an RX stream FIFO.
module uart_host_ctrl #(
  parameter int unsigned FIFO_DEPTH  = 8,
  parameter logic [7:0]  BAUD_DIV    = 8'd27,
  parameter bit          INT_EN      = 1'b1,
  parameter int unsigned POLL_CYCLES = 64
) (
  input  logic                        clk,
  input  logic                        arst_n,
  output logic                        we,
  output logic                        ce,
  output logic [1:0]                  adr,
  output logic [7:0]                  dat_o,
  output logic                        dat_oe,
  input  logic [7:0]                  dat_i,
  input  logic                        inter,
  input  logic [7:0]                  tx_data,
  input  logic                        tx_valid,
  output logic                        tx_ready,
  output logic [7:0]                  rx_data,
  output logic                        rx_valid,
  input  logic                        rx_ready,
  output logic [$clog2(FIFO_DEPTH):0] tx_level,
  output logic [$clog2(FIFO_DEPTH):0] rx_level,
  output logic                        spurious
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(POLL_CYCLES) + 1;
  localparam logic [CW-1:0] POLL_LAST = CW'(POLL_CYCLES - 1);
  localparam logic [AW:0]   FULL_LVL  = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [3:0] {
    S_INIT_BAUD, S_GAP_BAUD, S_INIT_CTRL, S_GAP_CTRL, S_IDLE, S_RD_STAT,
    S_GAP_STAT, S_DECIDE, S_RD_DATA, S_GAP_RDAT, S_WR_DATA, S_GAP_WDAT
  } state_e;

  state_e          state_q, state_d;
  logic            run_q, ready_q, ready_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            via_int_q, via_int_d;
  logic            spur_q, spur_d;
  logic [1:0]      stat_q, stat_d;

  logic [7:0]      tx_mem_q [FIFO_DEPTH];
  logic [7:0]      rx_mem_q [FIFO_DEPTH];
  logic [AW-1:0]   tx_wr_q, tx_rd_q, rx_wr_q, rx_rd_q;
  logic [AW:0]     tx_lvl_q, rx_lvl_q;
  logic            tx_push, tx_pop, rx_push, rx_pop, rx_full;

  assign rx_full  = (rx_lvl_q == FULL_LVL);
  assign tx_ready = ready_q && (tx_lvl_q != FULL_LVL);
  assign tx_push  = tx_valid && tx_ready;
  assign rx_valid = (rx_lvl_q != '0);
  assign rx_pop   = rx_valid && rx_ready;
  assign rx_data  = rx_valid ? rx_mem_q[rx_rd_q] : 8'h00;
  assign tx_level = tx_lvl_q;
  assign rx_level = rx_lvl_q;
  assign spurious = spur_q;

  // run_q holds the bus quiet until the first edge after reset release.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q   <= S_INIT_BAUD;
      run_q     <= 1'b0;
      ready_q   <= 1'b0;
      cnt_q     <= '0;
      via_int_q <= 1'b0;
      spur_q    <= 1'b0;
      stat_q    <= 2'b00;
    end else begin
      state_q   <= state_d;
      run_q     <= 1'b1;
      ready_q   <= ready_d;
      cnt_q     <= cnt_d;
      via_int_q <= via_int_d;
      spur_q    <= spur_d;
      stat_q    <= stat_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    ready_d   = ready_q;
    cnt_d     = cnt_q;
    via_int_d = via_int_q;
    spur_d    = spur_q;
    stat_d    = stat_q;
    rx_push   = 1'b0;
    tx_pop    = 1'b0;
    if (run_q) begin
      case (state_q)
        S_INIT_BAUD: state_d = S_GAP_BAUD;
        S_GAP_BAUD:  state_d = S_INIT_CTRL;
        S_INIT_CTRL: state_d = S_GAP_CTRL;
        S_GAP_CTRL: begin
          state_d = S_IDLE;
          ready_d = 1'b1;
        end
        S_IDLE: begin
          if (INT_EN && inter) begin
            state_d   = S_RD_STAT;
            via_int_d = 1'b1;
            cnt_d     = '0;
          end else if (cnt_q == POLL_LAST) begin
            state_d   = S_RD_STAT;
            via_int_d = 1'b0;
            cnt_d     = '0;
          end else if (!INT_EN || tx_lvl_q != '0) begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        S_RD_STAT: begin
          stat_d  = dat_i[1:0];
          state_d = S_GAP_STAT;
        end
        S_GAP_STAT: state_d = S_DECIDE;
        S_DECIDE: begin
          // Only the first status after an interrupt entry can be spurious.
          via_int_d = 1'b0;
          if (via_int_q && stat_q == 2'b00) spur_d = 1'b1;
          if (stat_q[0] && !rx_full)             state_d = S_RD_DATA;
          else if (stat_q[1] && tx_lvl_q != '0)  state_d = S_WR_DATA;
          else                                   state_d = S_IDLE;
        end
        S_RD_DATA: begin
          rx_push = !rx_full;
          state_d = S_GAP_RDAT;
        end
        S_GAP_RDAT: state_d = S_RD_STAT;
        S_WR_DATA: begin
          tx_pop  = 1'b1;
          state_d = S_GAP_WDAT;
        end
        S_GAP_WDAT: state_d = S_IDLE;
        default:    state_d = S_INIT_BAUD;
      endcase
    end
  end

  always_comb begin
    we     = 1'b0;
    ce     = 1'b0;
    adr    = 2'd0;
    dat_o  = 8'h00;
    dat_oe = 1'b0;
    if (run_q) begin
      case (state_q)
        S_INIT_BAUD: begin
          ce = 1'b1; we = 1'b1; dat_oe = 1'b1; adr = 2'd3; dat_o = BAUD_DIV;
        end
        S_INIT_CTRL: begin
          ce = 1'b1; we = 1'b1; dat_oe = 1'b1; adr = 2'd2; dat_o = {7'b0, INT_EN};
        end
        S_RD_STAT: begin
          ce = 1'b1; adr = 2'd1;
        end
        S_RD_DATA: begin
          ce = 1'b1; adr = 2'd0;
        end
        S_WR_DATA: begin
          ce = 1'b1; we = 1'b1; dat_oe = 1'b1; adr = 2'd0; dat_o = tx_mem_q[tx_rd_q];
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      tx_wr_q  <= '0;
      tx_rd_q  <= '0;
      tx_lvl_q <= '0;
      rx_wr_q  <= '0;
      rx_rd_q  <= '0;
      rx_lvl_q <= '0;
    end else begin
      if (tx_push) tx_wr_q <= tx_wr_q + 1'b1;
      if (tx_pop)  tx_rd_q <= tx_rd_q + 1'b1;
      if (tx_push && !tx_pop)      tx_lvl_q <= tx_lvl_q + 1'b1;
      else if (!tx_push && tx_pop) tx_lvl_q <= tx_lvl_q - 1'b1;
      if (rx_push) rx_wr_q <= rx_wr_q + 1'b1;
      if (rx_pop)  rx_rd_q <= rx_rd_q + 1'b1;
      if (rx_push && !rx_pop)      rx_lvl_q <= rx_lvl_q + 1'b1;
      else if (!rx_push && rx_pop) rx_lvl_q <= rx_lvl_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (tx_push) tx_mem_q[tx_wr_q] <= tx_data;
    if (rx_push) rx_mem_q[rx_wr_q] <= dat_i;
  end

endmodule

// File: tb/tb_uart_host_ctrl.sv
// Bench for uart_host_ctrl: an interrupt-mode instance driven by a small UART model
// with TX/RX scoreboards, plus a polling-mode instance for the status-poll path.
`timescale 1ns/1ps
module tb_uart_host_ctrl;
  localparam int DEPTH = 8;
  localparam int LW    = $clog2(DEPTH) + 1;
  localparam int POLL  = 64;

  logic clk = 1'b0;
  logic arst_n;
  always #5 clk = ~clk;

  logic          we, ce, dat_oe, inter, tx_valid, tx_ready, rx_valid, rx_ready, spurious;
  logic [1:0]    adr;
  logic [7:0]    dat_o, dat_i, tx_data, rx_data;
  logic [LW-1:0] tx_level, rx_level;

  logic          p_we, p_ce, p_dat_oe, p_inter, p_tx_valid, p_tx_ready, p_rx_valid, p_rx_ready, p_spurious;
  logic [1:0]    p_adr;
  logic [7:0]    p_dat_o, p_dat_i, p_tx_data, p_rx_data;
  logic [LW-1:0] p_tx_level, p_rx_level;

  uart_host_ctrl #(.FIFO_DEPTH(DEPTH), .BAUD_DIV(8'd27), .INT_EN(1'b1), .POLL_CYCLES(POLL)) dut (
    .clk(clk), .arst_n(arst_n), .we(we), .ce(ce), .adr(adr), .dat_o(dat_o), .dat_oe(dat_oe),
    .dat_i(dat_i), .inter(inter), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready), .tx_level(tx_level),
    .rx_level(rx_level), .spurious(spurious));

  uart_host_ctrl #(.FIFO_DEPTH(DEPTH), .BAUD_DIV(8'd27), .INT_EN(1'b0), .POLL_CYCLES(POLL)) dut_p (
    .clk(clk), .arst_n(arst_n), .we(p_we), .ce(p_ce), .adr(p_adr), .dat_o(p_dat_o), .dat_oe(p_dat_oe),
    .dat_i(p_dat_i), .inter(p_inter), .tx_data(p_tx_data), .tx_valid(p_tx_valid), .tx_ready(p_tx_ready),
    .rx_data(p_rx_data), .rx_valid(p_rx_valid), .rx_ready(p_rx_ready), .tx_level(p_tx_level),
    .rx_level(p_rx_level), .spurious(p_spurious));

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int n_stat_reads = 0, n_data_reads = 0, last_stat_cyc = 0, last_wr_cyc = 0;
  int p_stat_reads = 0, p_data_reads = 0, p_last_stat = 0, p_prev_stat = 0;
  logic       m_tx_empty = 1'b0;
  logic       m_force_inter = 1'b0;
  logic [7:0] p_stat = 8'h00;
  logic [7:0] p_byte = 8'h00;
  logic [7:0] rx_q[$];
  logic [7:0] exp_rx[$];
  logic [7:0] exp_tx[$];
  logic [7:0] p_exp[$];
  logic [9:0] wr_log[$];

  // One cycle: UART models respond to the access visible this cycle, then settle.
  task automatic step();
    @(negedge clk);
    cyc++;
    if (ce && !we && adr == 2'd1) begin
      dat_i = {6'b0, m_tx_empty, (rx_q.size() != 0)};
      n_stat_reads++;
      last_stat_cyc = cyc;
    end else if (ce && !we && adr == 2'd0) begin
      if (rx_q.size() != 0) dat_i = rx_q.pop_front();
      else dat_i = 8'h00;
      n_data_reads++;
    end else begin
      dat_i = 8'h00;
    end
    if (ce && we) begin
      wr_log.push_back({adr, dat_o});
      last_wr_cyc = cyc;
    end
    inter = m_force_inter || (rx_q.size() != 0);
    if (p_ce && !p_we && p_adr == 2'd1) begin
      p_dat_i = p_stat;
      p_stat_reads++;
      p_prev_stat = p_last_stat;
      p_last_stat = cyc;
    end else if (p_ce && !p_we && p_adr == 2'd0) begin
      p_dat_i = p_byte;
      p_stat = 8'h00;
      p_data_reads++;
    end else begin
      p_dat_i = 8'h00;
    end
    #1;
  endtask

  task automatic test_reset();
    logic [31:0] v;
    arst_n = 1'b0;
    tx_valid = 1'b0; tx_data = 8'h00; rx_ready = 1'b0; dat_i = 8'h00; inter = 1'b0;
    p_tx_valid = 1'b0; p_tx_data = 8'h00; p_rx_ready = 1'b1; p_dat_i = 8'h00; p_inter = 1'b0;
    repeat (3) step();
    v = {we, ce, adr, dat_o, dat_oe, tx_ready, rx_valid, rx_data, tx_level, rx_level, spurious};
    n_checks++;
    if (v !== 32'h0) begin
      n_errors++;
      $display("FAIL reset_outputs: got %h, expected 00000000", v);
    end
    v = {p_we, p_ce, p_adr, p_dat_o, p_dat_oe, p_tx_ready, p_rx_valid, p_rx_data, p_tx_level, p_rx_level, p_spurious};
    n_checks++;
    if (v !== 32'h0) begin
      n_errors++;
      $display("FAIL reset_outputs_poll: got %h, expected 00000000", v);
    end
  endtask

  task automatic test_init();
    int waited = 0;
    arst_n = 1'b1;
    while (!ce && waited < 10) begin step(); waited++; end
    n_checks++;
    if ({ce, we, dat_oe, adr, dat_o} !== {3'b111, 2'd3, 8'h1B}) begin
      n_errors++;
      $display("FAIL init_baud_write: got %h, expected %h", {ce, we, dat_oe, adr, dat_o}, {3'b111, 2'd3, 8'h1B});
    end
    step();
    n_checks++;
    if (ce !== 1'b0) begin
      n_errors++;
      $display("FAIL init_gap: ce got %b, expected 0", ce);
    end
    step();
    n_checks++;
    if ({ce, we, dat_oe, adr, dat_o, tx_ready} !== {3'b111, 2'd2, 8'h01, 1'b0}) begin
      n_errors++;
      $display("FAIL init_ctrl_write: got %h, expected %h", {ce, we, dat_oe, adr, dat_o, tx_ready}, {3'b111, 2'd2, 8'h01, 1'b0});
    end
    n_checks++;
    if ({p_adr, p_dat_o} !== {2'd2, 8'h00}) begin
      n_errors++;
      $display("FAIL init_ctrl_poll_mode: got %h, expected %h", {p_adr, p_dat_o}, {2'd2, 8'h00});
    end
    step();
    n_checks++;
    if (tx_ready !== 1'b0) begin
      n_errors++;
      $display("FAIL tx_ready_early: got %b, expected 0", tx_ready);
    end
    step();
    n_checks++;
    if (tx_ready !== 1'b1) begin
      n_errors++;
      $display("FAIL tx_ready_idle: got %b, expected 1", tx_ready);
    end
    wr_log.delete();
  endtask

  task automatic test_tx();
    int waited = 0;
    logic [9:0] got, want;
    m_tx_empty = 1'b1;
    tx_data = 8'hA5; tx_valid = 1'b1;
    exp_tx.push_back(8'hA5);
    step();
    tx_valid = 1'b0;
    n_checks++;
    if (tx_level !== LW'(1)) begin
      n_errors++;
      $display("FAIL tx_level_push: got %0d, expected 1", tx_level);
    end
    while (wr_log.size() == 0 && waited < 200) begin step(); waited++; end
    n_checks++;
    if (wr_log.size() == 0) begin
      n_errors++;
      $display("FAIL tx_write_timeout: got no data write, expected write of a5");
    end else begin
      got = wr_log.pop_front();
      want = {2'd0, exp_tx.pop_front()};
      if (got !== want) begin
        n_errors++;
        $display("FAIL tx_write: got %h, expected %h", got, want);
      end
      n_checks++;
      if (last_wr_cyc - last_stat_cyc != 3) begin
        n_errors++;
        $display("FAIL tx_stat_to_write: got %0d cycles, expected 3", last_wr_cyc - last_stat_cyc);
      end
    end
    step();
    n_checks++;
    if (tx_level !== LW'(0)) begin
      n_errors++;
      $display("FAIL tx_level_drained: got %0d, expected 0", tx_level);
    end
  endtask

  task automatic test_back_to_back();
    int waited = 0;
    logic [9:0] got, want;
    m_tx_empty = 1'b0;
    for (int i = 0; i < DEPTH + 1; i++) begin
      tx_data = 8'h30 + 8'(i);
      tx_valid = 1'b1;
      if (i < DEPTH) exp_tx.push_back(tx_data);
      step();
    end
    tx_valid = 1'b0;
    n_checks++;
    if ({tx_level, tx_ready} !== {LW'(DEPTH), 1'b0}) begin
      n_errors++;
      $display("FAIL tx_full: got level %0d ready %b, expected level %0d ready 0", tx_level, tx_ready, DEPTH);
    end
    repeat (100) step();
    n_checks++;
    if (wr_log.size() != 0 || tx_level !== LW'(DEPTH)) begin
      n_errors++;
      $display("FAIL tx_hold_busy: got %0d writes level %0d, expected 0 writes level %0d", wr_log.size(), tx_level, DEPTH);
    end
    m_tx_empty = 1'b1;
    while (exp_tx.size() != 0 && waited < 1000) begin
      if (wr_log.size() != 0) begin
        got = wr_log.pop_front();
        want = {2'd0, exp_tx.pop_front()};
        n_checks++;
        if (got !== want) begin
          n_errors++;
          $display("FAIL tx_b2b_order: got %h, expected %h", got, want);
        end
      end
      step();
      waited++;
    end
    n_checks++;
    if (exp_tx.size() != 0) begin
      n_errors++;
      $display("FAIL tx_b2b_timeout: got %0d bytes outstanding, expected 0", exp_tx.size());
    end
    step();
    n_checks++;
    if ({tx_level, tx_ready} !== {LW'(0), 1'b1}) begin
      n_errors++;
      $display("FAIL tx_b2b_empty: got level %0d ready %b, expected level 0 ready 1", tx_level, tx_ready);
    end
  endtask

  task automatic test_rx_inter();
    int waited = 0;
    int rd0, acc;
    logic [7:0] want;
    m_tx_empty = 1'b0;
    rx_ready = 1'b0;
    rd0 = n_data_reads;
    rx_q.push_back(8'h3C);
    exp_rx.push_back(8'h3C);
    while (!rx_valid && waited < 50) begin step(); waited++; end
    n_checks++;
    if (!rx_valid) begin
      n_errors++;
      $display("FAIL rx_valid_timeout: got rx_valid 0, expected 1");
    end else begin
      want = exp_rx.pop_front();
      if (rx_data !== want) begin
        n_errors++;
        $display("FAIL rx_data: got %h, expected %h", rx_data, want);
      end
    end
    n_checks++;
    if (rx_level !== LW'(1)) begin
      n_errors++;
      $display("FAIL rx_level_one: got %0d, expected 1", rx_level);
    end
    repeat (6) step();
    acc = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (ce) acc++;
    end
    n_checks++;
    if (acc != 0 || n_data_reads - rd0 != 1) begin
      n_errors++;
      $display("FAIL rx_back_to_idle: got %0d accesses %0d data reads, expected 0 and 1", acc, n_data_reads - rd0);
    end
    rx_ready = 1'b1;
    step();
    rx_ready = 1'b0;
    n_checks++;
    if ({rx_level, rx_valid, rx_data} !== {LW'(0), 1'b0, 8'h00}) begin
      n_errors++;
      $display("FAIL rx_consumed: got level %0d valid %b data %h, expected 0 0 00", rx_level, rx_valid, rx_data);
    end
  endtask

  task automatic test_backpressure();
    int waited = 0;
    int rd0;
    logic [7:0] b, want;
    rx_ready = 1'b0;
    rd0 = n_data_reads;
    for (int i = 0; i < DEPTH + 2; i++) begin
      b = 8'($urandom_range(0, 255));
      rx_q.push_back(b);
      exp_rx.push_back(b);
    end
    repeat (150) step();
    n_checks++;
    if (rx_level !== LW'(DEPTH) || n_data_reads - rd0 != DEPTH || rx_q.size() != 2) begin
      n_errors++;
      $display("FAIL rx_backpressure: got level %0d reads %0d pending %0d, expected %0d %0d 2",
               rx_level, n_data_reads - rd0, rx_q.size(), DEPTH, DEPTH);
    end
    n_checks++;
    if (spurious !== 1'b0) begin
      n_errors++;
      $display("FAIL rx_full_not_spurious: got %b, expected 0", spurious);
    end
    rx_ready = 1'b1;
    while (exp_rx.size() != 0 && waited < 300) begin
      if (rx_valid) begin
        want = exp_rx.pop_front();
        n_checks++;
        if (rx_data !== want) begin
          n_errors++;
          $display("FAIL rx_drain_order: got %h, expected %h", rx_data, want);
        end
      end
      step();
      waited++;
    end
    rx_ready = 1'b0;
    n_checks++;
    if (exp_rx.size() != 0 || n_data_reads - rd0 != DEPTH + 2) begin
      n_errors++;
      $display("FAIL rx_drain_done: got %0d left %0d reads, expected 0 left %0d reads", exp_rx.size(), n_data_reads - rd0, DEPTH + 2);
    end
  endtask

  task automatic test_poll();
    int waited = 0;
    int s0;
    logic [7:0] want;
    s0 = p_stat_reads;
    while (p_stat_reads < s0 + 2 && waited < 300) begin step(); waited++; end
    n_checks++;
    if (p_stat_reads < s0 + 2 || p_last_stat - p_prev_stat != POLL + 3) begin
      n_errors++;
      $display("FAIL poll_interval: got %0d cycles, expected %0d", p_last_stat - p_prev_stat, POLL + 3);
    end
    p_byte = 8'h5E;
    p_exp.push_back(8'h5E);
    p_stat = 8'h01;
    waited = 0;
    while (!p_rx_valid && waited < 200) begin step(); waited++; end
    n_checks++;
    if (!p_rx_valid) begin
      n_errors++;
      $display("FAIL poll_rx_timeout: got rx_valid 0, expected 1");
    end else begin
      want = p_exp.pop_front();
      if (p_rx_data !== want || p_data_reads != 1) begin
        n_errors++;
        $display("FAIL poll_rx_data: got %h after %0d reads, expected %h after 1", p_rx_data, p_data_reads, want);
      end
    end
  endtask

  task automatic test_spurious();
    int waited = 0;
    n_checks++;
    if (spurious !== 1'b0) begin
      n_errors++;
      $display("FAIL spurious_clear_before: got %b, expected 0", spurious);
    end
    m_tx_empty = 1'b0;
    m_force_inter = 1'b1;
    while (!spurious && waited < 30) begin step(); waited++; end
    n_checks++;
    if (spurious !== 1'b1) begin
      n_errors++;
      $display("FAIL spurious_set: got %b, expected 1", spurious);
    end
    m_force_inter = 1'b0;
    repeat (20) step();
    n_checks++;
    if (spurious !== 1'b1) begin
      n_errors++;
      $display("FAIL spurious_sticky: got %b, expected 1", spurious);
    end
  endtask

  task automatic test_reset_mid();
    int waited = 0;
    m_tx_empty = 1'b0;
    rx_q.push_back(8'h77);
    while (!(ce && !we && adr == 2'd0) && waited < 30) begin step(); waited++; end
    n_checks++;
    if (!(ce && !we && adr == 2'd0)) begin
      n_errors++;
      $display("FAIL reset_mid_no_rd_data: got ce %b we %b adr %0d, expected data read", ce, we, adr);
    end
    #1 arst_n = 1'b0;
    #1;
    n_checks++;
    if ({ce, we, dat_oe, tx_ready, spurious} !== 5'b0) begin
      n_errors++;
      $display("FAIL reset_mid_bus: got %b, expected 00000", {ce, we, dat_oe, tx_ready, spurious});
    end
    n_checks++;
    if ({tx_level, rx_level} !== {LW'(0), LW'(0)}) begin
      n_errors++;
      $display("FAIL reset_mid_levels: got tx %0d rx %0d, expected 0 0", tx_level, rx_level);
    end
    step();
    step();
    rx_q.delete(); exp_rx.delete(); wr_log.delete();
    m_force_inter = 1'b0;
    arst_n = 1'b1;
    waited = 0;
    while (wr_log.size() < 2 && waited < 20) begin step(); waited++; end
    n_checks++;
    if (wr_log.size() < 2) begin
      n_errors++;
      $display("FAIL reinit_timeout: got %0d writes, expected 2", wr_log.size());
    end else if (wr_log[0] !== {2'd3, 8'h1B} || wr_log[1] !== {2'd2, 8'h01}) begin
      n_errors++;
      $display("FAIL reinit_sequence: got %h %h, expected %h %h", wr_log[0], wr_log[1], {2'd3, 8'h1B}, {2'd2, 8'h01});
    end
  endtask

  initial begin
    test_reset();
    test_init();
    test_tx();
    test_back_to_back();
    test_rx_inter();
    test_backpressure();
    test_poll();
    test_spurious();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got no finish by 1 ms, expected bench to complete");
    $fatal(1);
  end

endmodule
